// File: rtl/floor_decoder_filtered.sv
// -----------------------------------------------------------------------------
// floor_decoder_filtered
//
// Debounced, registered floor decoder. A binary floor code from the car
// position encoder is only accepted after it has been presented valid and
// unchanged on STABLE_CYC consecutive rising edges. An accepted legal code
// becomes the committed floor (binary and one-hot) and pulses `arrive` for
// one cycle when the floor actually changes. An accepted code outside
// 0..FLOORS-1 never reaches the floor outputs; it raises a sticky range_err.
//
// Parameters:
//   FLOORS      number of floors (2..2^W)
//   W           floor code width
//   STABLE_CYC  consecutive identical valid samples needed to accept a code
//   INIT_FLOOR  floor committed at reset (< FLOORS)
//
// Ports:
//   clk           in   rising-edge clock
//   rst           in   asynchronous, active-high reset
//   floor_code    in   [W-1:0] binary floor code from the position encoder
//   code_valid    in   floor_code is meaningful this cycle
//   err_clr       in   clears range_err (a same-edge error lock wins)
//   floor_onehot  out  [FLOORS-1:0] one-hot of the committed floor
//   cur_floor     out  [W-1:0] binary of the committed floor
//   arrive        out  one-cycle pulse after a new floor is committed
//   range_err     out  sticky: a stable out-of-range code was accepted
// -----------------------------------------------------------------------------
module floor_decoder_filtered #(
  parameter int FLOORS     = 11,
  parameter int W          = 4,
  parameter int STABLE_CYC = 3,
  parameter int INIT_FLOOR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [W-1:0]      floor_code,
  input  logic              code_valid,
  input  logic              err_clr,
  output logic [FLOORS-1:0] floor_onehot,
  output logic [W-1:0]      cur_floor,
  output logic              arrive,
  output logic              range_err
);

  // Counter just wide enough to hold STABLE_CYC.
  localparam int CW = $clog2(STABLE_CYC + 1);

  localparam logic [CW-1:0]     CNT_ZERO    = CW'(0);
  localparam logic [CW-1:0]     CNT_ONE     = CW'(1);
  localparam logic [CW-1:0]     CNT_LOCK    = CW'(STABLE_CYC);
  localparam logic [W:0]        FLOORS_C    = (W + 1)'(FLOORS);
  localparam logic [FLOORS-1:0] ONEHOT_BIT0 = {{(FLOORS - 1){1'b0}}, 1'b1};
  localparam logic [W-1:0]      INIT_CUR    = W'(INIT_FLOOR);
  localparam logic [FLOORS-1:0] INIT_ONEHOT = ONEHOT_BIT0 << INIT_FLOOR;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [W-1:0]      cand_q,         cand_d;
  logic [CW-1:0]     cnt_q,          cnt_d;
  logic [W-1:0]      cur_floor_q,    cur_floor_d;
  logic [FLOORS-1:0] floor_onehot_q, floor_onehot_d;
  logic              arrive_q,       arrive_d;
  logic              range_err_q,    range_err_d;

  logic              restart_s;
  logic              lock_s;
  logic              legal_s;

  // Stability filter: track the candidate code and how many consecutive
  // valid edges it has been seen on.
  always_comb begin
    cand_d    = cand_q;
    cnt_d     = cnt_q;
    restart_s = 1'b0;
    if (!code_valid) begin
      // Any gap in validity discards the run, even if the code is unchanged.
      cnt_d = CNT_ZERO;
    end else if ((cnt_q == CNT_ZERO) || (floor_code != cand_q)) begin
      cand_d    = floor_code;
      cnt_d     = CNT_ONE;
      restart_s = 1'b1;
    end else if (cnt_q < CNT_LOCK) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      // Saturated: a locked run just holds.
      cnt_d = cnt_q;
    end
  end

  // Lock event: this edge brings the count up to STABLE_CYC. The restart
  // term matters only for STABLE_CYC == 1, where a new code seen while
  // already saturated must lock again even though cnt stays at 1.
  always_comb begin
    lock_s = 1'b0;
    if (code_valid && (cnt_d == CNT_LOCK) &&
        (restart_s || (cnt_q != CNT_LOCK))) begin
      lock_s = 1'b1;
    end else begin
      lock_s = 1'b0;
    end
  end

  // Range check on the code being locked (cand_d is the code seen this edge).
  always_comb begin
    legal_s = 1'b0;
    if ({1'b0, cand_d} < FLOORS_C) begin
      legal_s = 1'b1;
    end else begin
      legal_s = 1'b0;
    end
  end

  // Commit logic: decide the next committed floor, arrival pulse and error.
  always_comb begin
    cur_floor_d    = cur_floor_q;
    floor_onehot_d = floor_onehot_q;
    arrive_d       = 1'b0;
    range_err_d    = range_err_q;

    if (err_clr) begin
      range_err_d = 1'b0;
    end else begin
      range_err_d = range_err_q;
    end

    if (lock_s) begin
      if (!legal_s) begin
        // Set overrides a same-edge clear; floor outputs keep last legal floor.
        range_err_d = 1'b1;
      end else if (cand_d != cur_floor_q) begin
        cur_floor_d    = cand_d;
        floor_onehot_d = ONEHOT_BIT0 << cand_d;
        arrive_d       = 1'b1;
      end else begin
        // Re-locking on the floor already committed is silent.
        arrive_d = 1'b0;
      end
    end else begin
      arrive_d = 1'b0;
    end
  end

  // Filter and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cand_q         <= {W{1'b0}};
      cnt_q          <= CNT_ZERO;
      cur_floor_q    <= INIT_CUR;
      floor_onehot_q <= INIT_ONEHOT;
      arrive_q       <= 1'b0;
      range_err_q    <= 1'b0;
    end else begin
      cand_q         <= cand_d;
      cnt_q          <= cnt_d;
      cur_floor_q    <= cur_floor_d;
      floor_onehot_q <= floor_onehot_d;
      arrive_q       <= arrive_d;
      range_err_q    <= range_err_d;
    end
  end

  assign floor_onehot = floor_onehot_q;
  assign cur_floor    = cur_floor_q;
  assign arrive       = arrive_q;
  assign range_err    = range_err_q;

  floor_decoder_filtered_chk #(
    .FLOORS (FLOORS),
    .W      (W)
  ) u_chk (
    .clk          (clk),
    .rst          (rst),
    .floor_onehot (floor_onehot_q),
    .cur_floor    (cur_floor_q)
  );

endmodule

// -----------------------------------------------------------------------------
// floor_decoder_filtered_chk
//
// Invariant checker for the committed-floor outputs; contains no logic that
// affects the design.
//
// Ports:
//   clk, rst      clock and asynchronous active-high reset of the decoder
//   floor_onehot  committed one-hot floor
//   cur_floor     committed binary floor
// -----------------------------------------------------------------------------
module floor_decoder_filtered_chk #(
  parameter int FLOORS = 11,
  parameter int W      = 4
) (
  input logic              clk,
  input logic              rst,
  input logic [FLOORS-1:0] floor_onehot,
  input logic [W-1:0]      cur_floor
);

  localparam logic [FLOORS-1:0] ONEHOT_BIT0 = {{(FLOORS - 1){1'b0}}, 1'b1};
  localparam logic [W:0]        FLOORS_C    = (W + 1)'(FLOORS);

  a_onehot : assert property (@(posedge clk) disable iff (rst)
    $onehot(floor_onehot))
    else $error("floor_onehot is not one-hot");

  a_match : assert property (@(posedge clk) disable iff (rst)
    floor_onehot == (ONEHOT_BIT0 << cur_floor))
    else $error("floor_onehot disagrees with cur_floor");

  a_legal : assert property (@(posedge clk) disable iff (rst)
    {1'b0, cur_floor} < FLOORS_C)
    else $error("cur_floor outside floor range");

endmodule

// File: tb/tb_floor_decoder_filtered.sv
// -----------------------------------------------------------------------------
// tb_floor_decoder_filtered
//
// Self-checking bench: directed scenarios followed by randomized stimulus,
// all compared against a behavioural model that counts raw run lengths.
// -----------------------------------------------------------------------------
module tb_floor_decoder_filtered;

  localparam int FLOORS     = 11;
  localparam int W          = 4;
  localparam int STABLE_CYC = 3;
  localparam int INIT_FLOOR = 0;

  logic              clk        = 1'b0;
  logic              rst        = 1'b0;
  logic [W-1:0]      floor_code = 4'd0;
  logic              code_valid = 1'b0;
  logic              err_clr    = 1'b0;
  logic [FLOORS-1:0] floor_onehot;
  logic [W-1:0]      cur_floor;
  logic              arrive;
  logic              range_err;

  int total = 0;
  int bad   = 0;

  // Behavioural model: unbounded run length of identical valid codes.
  int m_run_len  = 0;
  int m_run_code = 0;
  int m_cur      = INIT_FLOOR;
  bit m_err      = 1'b0;
  bit m_arrive   = 1'b0;

  floor_decoder_filtered #(
    .FLOORS     (FLOORS),
    .W          (W),
    .STABLE_CYC (STABLE_CYC),
    .INIT_FLOOR (INIT_FLOOR)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .floor_code   (floor_code),
    .code_valid   (code_valid),
    .err_clr      (err_clr),
    .floor_onehot (floor_onehot),
    .cur_floor    (cur_floor),
    .arrive       (arrive),
    .range_err    (range_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run_len  = 0;
    m_run_code = 0;
    m_cur      = INIT_FLOOR;
    m_err      = 1'b0;
    m_arrive   = 1'b0;
  endtask

  // A code is accepted when its run of consecutive valid samples reaches
  // exactly STABLE_CYC; longer runs do not re-accept.
  task automatic model_edge(input bit v, input int c, input bit clr);
    bit lock;
    m_arrive = 1'b0;
    if (!v) begin
      m_run_len = 0;
    end else if (m_run_len == 0 || c != m_run_code) begin
      m_run_code = c;
      m_run_len  = 1;
    end else begin
      m_run_len = m_run_len + 1;
    end
    lock = v && (m_run_len == STABLE_CYC);
    if (clr) m_err = 1'b0;
    if (lock) begin
      if (c < FLOORS) begin
        if (c != m_cur) begin
          m_cur    = c;
          m_arrive = 1'b1;
        end
      end else begin
        m_err = 1'b1;
      end
    end
  endtask

  task automatic check_outs(input string tag);
    logic [FLOORS-1:0] exp_oh;
    exp_oh = 11'd1 << m_cur;
    chk({tag, ".cur"},    32'(cur_floor),    32'(m_cur));
    chk({tag, ".onehot"}, 32'(floor_onehot), 32'(exp_oh));
    chk({tag, ".arrive"}, 32'(arrive),       32'(m_arrive));
    chk({tag, ".err"},    32'(range_err),    32'(m_err));
    chk({tag, ".ones"},   32'($countones(floor_onehot)), 32'd1);
  endtask

  task automatic step(input bit v, input int c, input bit clr, input string tag);
    code_valid = v;
    floor_code = W'(c);
    err_clr    = clr;
    @(posedge clk);
    model_edge(v, c, clr);
    #1;
    check_outs(tag);
  endtask

  // Assert rst between edges, check the immediate response, release mid-cycle.
  task automatic do_reset(input string tag);
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk({tag, ".rst_cur"},    32'(cur_floor),    32'd0);
    chk({tag, ".rst_onehot"}, 32'(floor_onehot), 32'h001);
    chk({tag, ".rst_arrive"}, 32'(arrive),       32'd0);
    chk({tag, ".rst_err"},    32'(range_err),    32'd0);
    @(posedge clk);
    #2 rst = 1'b0;
  endtask

  initial begin
    int code;
    do_reset("init");

    // Clean commit of floor 7 on the third edge, single-cycle arrive.
    step(1'b1, 7, 1'b0, "clean1");
    step(1'b1, 7, 1'b0, "clean2");
    chk("clean2.nocommit", 32'(cur_floor), 32'd0);
    step(1'b1, 7, 1'b0, "clean3");
    chk("clean3.cur",    32'(cur_floor),    32'd7);
    chk("clean3.onehot", 32'(floor_onehot), 32'h080);
    chk("clean3.arrive", 32'(arrive),       32'd1);
    step(1'b1, 7, 1'b0, "clean4");
    chk("clean4.arrive", 32'(arrive), 32'd0);
    step(1'b1, 7, 1'b0, "clean5");

    // Glitch: 5,5,6,5,5,5 commits 5 only on the sixth edge.
    step(1'b1, 5, 1'b0, "gl1");
    step(1'b1, 5, 1'b0, "gl2");
    step(1'b1, 6, 1'b0, "gl3");
    step(1'b1, 5, 1'b0, "gl4");
    step(1'b1, 5, 1'b0, "gl5");
    chk("gl5.still7", 32'(cur_floor), 32'd7);
    step(1'b1, 5, 1'b0, "gl6");
    chk("gl6.cur",    32'(cur_floor), 32'd5);
    chk("gl6.arrive", 32'(arrive),    32'd1);

    // Valid drop restarts the count even with the same code.
    step(1'b1, 4, 1'b0, "dr1");
    step(1'b1, 4, 1'b0, "dr2");
    step(1'b0, 4, 1'b0, "dr3");
    step(1'b1, 4, 1'b0, "dr4");
    step(1'b1, 4, 1'b0, "dr5");
    chk("dr5.still5", 32'(cur_floor), 32'd5);
    step(1'b1, 4, 1'b0, "dr6");
    chk("dr6.cur", 32'(cur_floor), 32'd4);

    // Same floor re-presented: no arrive.
    for (int i = 0; i < 3; i++) step(1'b1, 2, 1'b0, "sf_a");
    chk("sf.cur2", 32'(cur_floor), 32'd2);
    step(1'b0, 0, 1'b0, "sf_gap");
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 2, 1'b0, "sf_b");
      chk("sf.noarrive", 32'(arrive), 32'd0);
    end

    // Range error, clear, and set-wins-over-clear.
    step(1'b0, 0, 1'b0, "re_gap");
    for (int i = 0; i < 3; i++) step(1'b1, 12, 1'b0, "re_a");
    chk("re.err",    32'(range_err),    32'd1);
    chk("re.cur",    32'(cur_floor),    32'd2);
    chk("re.onehot", 32'(floor_onehot), 32'h004);
    chk("re.arrive", 32'(arrive),       32'd0);
    step(1'b0, 0, 1'b1, "re_clr");
    chk("re.cleared", 32'(range_err), 32'd0);
    step(1'b1, 13, 1'b0, "re_b1");
    step(1'b1, 13, 1'b0, "re_b2");
    step(1'b1, 13, 1'b1, "re_b3");
    chk("re.setwins", 32'(range_err), 32'd1);
    step(1'b0, 0, 1'b1, "re_clr2");

    // Reset mid-count discards the partial run.
    step(1'b1, 9, 1'b0, "mr1");
    step(1'b1, 9, 1'b0, "mr2");
    do_reset("mid");
    step(1'b1, 9, 1'b0, "mr3");
    step(1'b1, 9, 1'b0, "mr4");
    chk("mr4.cur0", 32'(cur_floor), 32'd0);
    step(1'b1, 9, 1'b0, "mr5");
    chk("mr5.cur9", 32'(cur_floor), 32'd9);

    // Exhaustive sweep of every code.
    for (int c = 0; c < 16; c++) begin
      for (int k = 0; k < 3; k++) step(1'b1, c, 1'b0, "sweep");
      if (c < FLOORS) begin
        chk("sweep.onehot", 32'(floor_onehot), 32'(1) << c);
      end else begin
        chk("sweep.err", 32'(range_err), 32'd1);
      end
    end

    // Randomized stimulus with sticky codes so runs often complete.
    code = 0;
    for (int n = 0; n < 600; n++) begin
      bit v;
      bit clr;
      v   = ($urandom_range(0, 99) < 88);
      clr = ($urandom_range(0, 99) < 6);
      if ($urandom_range(0, 99) < 30) code = $urandom_range(0, 15);
      step(v, code, clr, "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/floor_decoder_filtered.md
# floor_decoder_filtered

Parametrised, registered successor to the combinational floor decoder. It accepts a binary floor code from the car-position logic and accepts the code only after it has stayed stable for a programmable number of cycles. It then outputs a one-hot floor indication, the committed binary floor and a one-cycle arrival strobe. Out-of-range codes raise a sticky error instead of being decoded. It sits between the position sensor/encoder and the floor lamps and controller FSM.

## Interface
- FLOORS, 11, number of floors; legal range 2..2^W
- W, 4, floor code width
- STABLE_CYC, 3, consecutive identical valid samples required to accept a code; ≥1
- INIT_FLOOR, 0, floor committed at reset; must be < FLOORS

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- floor_code  in  W  binary floor code from the position encoder
- code_valid  in  1  floor_code is meaningful this cycle
- err_clr  in  1  clears range_err
- floor_onehot  out  FLOORS  registered one-hot of the committed floor; bit k means floor k
- cur_floor  out  W  registered binary of the committed floor
- arrive  out  1  one-cycle pulse after a new floor is committed
- range_err  out  1  sticky; a stable code ≥ FLOORS was seen

## Operation
- Internal registers:
  - cand (W bits): candidate code.
  - cnt: width clog2(STABLE_CYC+1), saturates at STABLE_CYC.
- Counter states:
  - EMPTY: cnt = 0.
  - COUNTING: 0 < cnt < STABLE_CYC.
  - LOCKED: cnt = STABLE_CYC.
- Per rising edge:
  - code_valid = 0: cnt ← 0, go to EMPTY. Outputs other than arrive hold.
  - code_valid = 1 and (cnt = 0 or floor_code ≠ cand): cand ← floor_code, cnt ← 1.
  - code_valid = 1 and floor_code = cand and cnt < STABLE_CYC: cnt ← cnt+1.
  - LOCKED with matching code: no change. Holds until the code changes or code_valid drops.
- Lock event: the edge on which the next value of cnt equals STABLE_CYC.
  - With STABLE_CYC = 1, this is the first valid edge.
  - A lock event occurs at most once per stable run.
- On a lock event with code c:
  - c < FLOORS and c ≠ cur_floor: cur_floor ← c, floor_onehot ← 1<<c, arrive ← 1.
  - c < FLOORS and c = cur_floor: no output change, arrive stays 0.
  - c ≥ FLOORS: range_err ← 1. cur_floor and floor_onehot hold the last legal floor.
- arrive is 0 on every edge that is not a qualifying commit.
- range_err:
  - err_clr = 1 clears it.
  - If an error lock event and err_clr occur on the same edge, set wins.
- floor_onehot is always exactly one-hot and always equals 1<<cur_floor.

## Timing
- Reset values (asynchronous, immediate):
  - cur_floor = INIT_FLOOR
  - floor_onehot = 1<<INIT_FLOOR
  - arrive = 0
  - range_err = 0
  - cnt = 0
  - cand = 0
- Reset asserted mid-count discards the partial run. Counting restarts from EMPTY on the first edge after rst falls.
- Latency: a code held valid and stable from edge 1 commits on edge STABLE_CYC. Outputs are visible after that edge.
- arrive is high for exactly the cycle following the commit edge.
- A code change on any edge restarts the count at 1 on that edge. The new code needs STABLE_CYC edges in total.
- A single-cycle code_valid drop restarts the count, even if the code is unchanged.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
Use FLOORS=11, W=4, STABLE_CYC=3, INIT_FLOOR=0.
- Reset:
  - Stimulus: assert rst asynchronously between edges.
  - Response: immediately cur_floor=0, floor_onehot=11'b000_0000_0001, arrive=0, range_err=0.
- Clean commit:
  - Stimulus: code_valid=1, floor_code=7 for 3 edges.
  - Response: after edge 3, cur_floor=7, floor_onehot=11'b000_1000_0000, arrive=1 for one cycle only. Holding the code further produces no further arrive.
- Glitch rejection:
  - Stimulus: codes 5,5,6,5,5,5.
  - Response: commit of 5 only after the 6th edge. No commit of 6.
  - Stimulus: code 4 twice, code_valid=0 for one cycle, then 4 again.
  - Response: commit on the 3rd valid edge after the drop.
- Same floor:
  - Stimulus: committed floor 2, then code 2 re-presented stably for 3 edges.
  - Response: no arrive, outputs unchanged.
- Range error:
  - Stimulus: code 12 stable for 3 edges.
  - Response: range_err=1, cur_floor/floor_onehot unchanged, arrive=0.
  - Stimulus: err_clr=1 on a later edge.
  - Response: range_err=0.
  - Stimulus: err_clr asserted on the same edge as a new error lock event.
  - Response: range_err remains 1.
- Exhaustive sweep:
  - Stimulus: all codes 0..15, each held 3 edges.
  - Response: codes 0..10 give floor_onehot exactly 1<<code. Codes 11..15 set range_err. floor_onehot is never zero and never multi-hot.
